// File: rtl/store_pkg.sv
// Shared definitions for the store alignment unit: funct3 size codes,
// FSM state encoding and the per-size base byte masks.
package store_pkg;

   localparam logic [2:0] SZ_BYTE = 3'b000;
   localparam logic [2:0] SZ_HALF = 3'b001;
   localparam logic [2:0] SZ_WORD = 3'b010;

   localparam logic [3:0] MASK_BYTE = 4'b0001;
   localparam logic [3:0] MASK_HALF = 4'b0011;
   localparam logic [3:0] MASK_WORD = 4'b1111;

   typedef enum logic [1:0] {IDLE, LO, HI} st_e;

   // Unknown encodings store a full word, same as SZ_WORD.
   function automatic logic [3:0] base_mask(input logic [2:0] size);
      case (size)
         SZ_BYTE: base_mask = MASK_BYTE;
         SZ_HALF: base_mask = MASK_HALF;
         SZ_WORD: base_mask = MASK_WORD;
         default: base_mask = MASK_WORD;
      endcase
   endfunction

   function automatic logic [31:0] byte_expand(input logic [3:0] mask);
      byte_expand = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
   endfunction

endpackage

// File: rtl/store_align_unit_if.sv
// Request and memory-write handshake bundle of the store alignment unit.
// slave = the unit itself, master = the execute stage / memory environment.
interface store_align_unit_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic [2:0]        req_size;
   logic              mem_valid;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_wmask;
   logic              done;
   logic              misalign_err;

   modport slave (
      input  req_valid, req_addr, req_wdata, req_size, mem_ready,
      output req_ready, mem_valid, mem_addr, mem_wdata, mem_wmask, done, misalign_err
   );

   modport master (
      output req_valid, req_addr, req_wdata, req_size, mem_ready,
      input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wmask, done, misalign_err
   );
endinterface

// File: rtl/store_lane_shift.sv
// Combinational size decode and lane shift: spreads a store over a 64-bit
// window (two words) and reports whether the upper word is touched.
module store_lane_shift
   import store_pkg::*;
(
   input  logic [1:0]  off,
   input  logic [2:0]  size,
   input  logic [31:0] data,
   output logic [31:0] lo_data,
   output logic [31:0] hi_data,
   output logic [3:0]  lo_mask,
   output logic [3:0]  hi_mask,
   output logic        split
);
   logic [3:0]  base;
   logic [31:0] data_sz;
   logic [63:0] wide;
   logic [7:0]  mask8;

   always_comb begin
      base    = base_mask(size);
      data_sz = data & byte_expand(base);
      wide    = {32'b0, data_sz} << {off, 3'b000};
      mask8   = {4'b0, base} << off;
   end

   assign lo_data = wide[31:0];
   assign hi_data = wide[63:32];
   assign lo_mask = mask8[3:0];
   assign hi_mask = mask8[7:4];
   assign split   = |mask8[7:4];

endmodule

// File: rtl/store_align_unit.sv
// Store alignment unit: turns a byte-addressed store into one or two
// word-aligned write beats. Build option: MISALIGN_TRAP_EN rejects splitting stores.
module store_align_unit
   import store_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input logic clk,
   input logic rst,
   store_align_unit_if.slave bus
);
   st_e state, state_nx;

   logic [31:0] lo_data, hi_data;
   logic [3:0]  lo_mask, hi_mask;
   logic        split, trap, latch;

   logic [31:0] hi_data_p0;
   logic [3:0]  hi_mask_p0;
   logic        split_p0;

   logic              valid_p1, valid_nx;
   logic [ADDR_W-1:0] addr_p1, addr_nx;
   logic [31:0]       wdata_p1, wdata_nx;
   logic [3:0]        wmask_p1, wmask_nx;
   logic              done_p1, done_nx;

   store_lane_shift u_shift (
      .off     (bus.req_addr[1:0]),
      .size    (bus.req_size),
      .data    (bus.req_wdata),
      .lo_data (lo_data),
      .hi_data (hi_data),
      .lo_mask (lo_mask),
      .hi_mask (hi_mask),
      .split   (split)
   );

`ifdef MISALIGN_TRAP_EN
   logic err_p1;
   assign trap = split;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_p1 <= 1'b0;
      else     err_p1 <= (state == IDLE) && bus.req_valid && trap;
   end

   assign bus.misalign_err = err_p1;
`else
   assign trap             = 1'b0;
   assign bus.misalign_err = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      valid_nx = valid_p1;
      addr_nx  = addr_p1;
      wdata_nx = wdata_p1;
      wmask_nx = wmask_p1;
      done_nx  = 1'b0;
      latch    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req_valid && !trap) begin
               latch    = 1'b1;
               state_nx = LO;
               valid_nx = 1'b1;
               addr_nx  = {bus.req_addr[ADDR_W-1:2], 2'b00};
               wdata_nx = lo_data;
               wmask_nx = lo_mask;
            end
         end
         LO: begin
            if (bus.mem_ready) begin
               if (split_p0) begin
                  state_nx = HI;
                  addr_nx  = addr_p1 + ADDR_W'(4);
                  wdata_nx = hi_data_p0;
                  wmask_nx = hi_mask_p0;
               end else begin
                  state_nx = IDLE;
                  valid_nx = 1'b0;
                  addr_nx  = '0;
                  wdata_nx = '0;
                  wmask_nx = '0;
                  done_nx  = 1'b1;
               end
            end
         end
         HI: begin
            if (bus.mem_ready) begin
               state_nx = IDLE;
               valid_nx = 1'b0;
               addr_nx  = '0;
               wdata_nx = '0;
               wmask_nx = '0;
               done_nx  = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // p0: upper beat held while the lower beat drains
   always_ff @(posedge clk) begin
      if (latch) begin
         hi_data_p0 <= hi_data;
         hi_mask_p0 <= hi_mask;
      end
   end

   // p1: registered bus outputs and FSM state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         split_p0 <= 1'b0;
         valid_p1 <= 1'b0;
         addr_p1  <= '0;
         wdata_p1 <= '0;
         wmask_p1 <= '0;
         done_p1  <= 1'b0;
      end else begin
         state    <= state_nx;
         if (latch) split_p0 <= split;
         valid_p1 <= valid_nx;
         addr_p1  <= addr_nx;
         wdata_p1 <= wdata_nx;
         wmask_p1 <= wmask_nx;
         done_p1  <= done_nx;
      end
   end

   assign bus.req_ready = (state == IDLE);
   assign bus.mem_valid = valid_p1;
   assign bus.mem_addr  = addr_p1;
   assign bus.mem_wdata = wdata_p1;
   assign bus.mem_wmask = wmask_p1;
   assign bus.done      = done_p1;

endmodule

// File: doc/store_align_unit.md
Name: store_align_unit

Overview:
Store-side counterpart to the load data extender. It takes a store request (byte address, register data, funct3 size) and produces word-aligned write data with per-byte write strobes for the data memory port. Misaligned stores that cross a word boundary are split into two sequential memory beats by a small FSM. It sits between the execute stage's store path and the data memory write interface.

Parameters:
ADDR_W, 32, byte-address width; memory word address is ADDR_W-2 bits, padded with 2'b00 on mem_addr.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  store request present
req_ready  out  1  unit can accept a request (high only in IDLE)
req_addr  in  ADDR_W  byte address of store
req_wdata  in  32  rs2 data, right-justified
req_size  in  3  funct3: 000 byte, 001 half, 010 word
mem_valid  out  1  write beat valid
mem_ready  in  1  memory accepts beat
mem_addr  out  ADDR_W  word-aligned beat address
mem_wdata  out  32  lane-aligned write data
mem_wmask  out  4  byte strobes, bit i = byte lane i
done  out  1  one-cycle pulse: store fully committed
misalign_err  out  1  one-cycle pulse (macro-dependent, see below)

Behaviour:
- Reset (async, immediate): state IDLE; mem_valid, done, misalign_err = 0; mem_addr, mem_wdata, mem_wmask = 0; req_ready = 1 once reset deasserts.
- Size decode: 000 -> base mask 0001, data[7:0]; 001 -> 0011, data[15:0]; 010 and all other encodings -> 1111, full word. Upper unused data bits forced to 0 before shifting.
- Alignment: off = req_addr[1:0]; 64-bit shifted data = {32'b0, data} << (8*off); 8-bit mask = {4'b0, base} << off. Low beat = bits [31:0] / mask[3:0]; high beat = [63:32] / mask[7:4]. Split needed when mask[7:4] != 0.
- FSM states: IDLE, LO, HI.
  - IDLE: req_ready=1. On req_valid, latch both beats, addresses, and split flag -> LO.
  - LO: mem_valid=1, mem_addr={req_addr[ADDR_W-1:2],2'b00}, low beat on bus. On mem_ready: split -> HI, else -> IDLE and pulse done next cycle.
  - HI: mem_valid=1, mem_addr=low address+4 (wraps modulo 2^ADDR_W; 0xFFFFFFFC -> 0x00000000), high beat on bus. On mem_ready -> IDLE and pulse done.
- Latency: request accepted at cycle T; first beat valid at T+1; aligned store with immediate mem_ready has done at T+2. A new request is accepted in the same cycle done pulses.
- Backpressure: while mem_valid && !mem_ready, mem_addr/wdata/wmask held stable; no beat is dropped or reordered.
- Outputs are registered; mem_valid is never asserted with mem_wmask == 0.
- Reset mid-operation: any pending beat is abandoned; no done pulse.

Optional Feature:
MISALIGN_TRAP_EN. When defined: half with off=3 or word with off!=0 is not written; the unit stays in IDLE, and misalign_err pulses for one cycle at T+1 with no mem_valid and no done. When undefined: split behaviour as above; misalign_err tied 0; HI state present.

Decomposition:
- Package store_pkg: size encodings SZ_BYTE/SZ_HALF/SZ_WORD (3-bit), state enum st_e {IDLE, LO, HI}, base-mask constants.
- Sub-module store_lane_shift: purely combinational size decode + shift producing both beats, both masks, and the split flag; instantiated once in store_align_unit.

Test Plan:
- sb addr 0x1001 data 0xAABBCCDD, mem_ready=1 -> single beat addr 0x1000, wdata 0x0000DD00, wmask 0010; done at T+2.
- sh addr 0x2002 data 0x12345678 -> single beat addr 0x2000, wdata 0x56780000, wmask 1100.
- sw addr 0x3003 data 0x11223344 (macro off) -> beat0 0x3000 / 0x44000000 / 1000; beat1 0x3004 / 0x00112233 / 0111; one done after beat1. Macro on: misalign_err pulse, no mem_valid.
- sw addr 0x4000 data 0xDEADBEEF, mem_ready low for 3 cycles -> bus held at 0x4000 / 0xDEADBEEF / 1111 all 3 cycles; done one cycle after the ready cycle.
- sh addr 0xFFFFFFFF data 0xBEEF (macro off) -> beat0 0xFFFFFFFC / 0xEF000000 / 1000; beat1 0x00000000 / 0x000000BE / 0001.
- Assert rst while in HI with mem_ready=0 -> outputs 0 immediately, no done; next request processed normally.
